// File: rtl/act_writeback.sv
// act_writeback: captures one activated row and streams it to the output buffer as LANES-wide beats.
// Define WB_ZERO_COUNT_EN to add a per-row count of zero-valued elements (zero_count).
module act_writeback #(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [SA_LENGTH*DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  output logic                                  mem_valid,
  input  logic                                  mem_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic signed [LANES*DATA_WIDTH-1:0]    mem_wdata,
  output logic                                  done,
  output logic                                  busy
`ifdef WB_ZERO_COUNT_EN
  ,
  output logic [$clog2(SA_LENGTH+1)-1:0]        zero_count
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a row, in_ready high
  // S_SEND | presenting beat r_beat until the buffer accepts it
  // S_DONE | one-cycle completion pulse
  localparam int BEATS = SA_LENGTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW    = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [CW-1:0]                  r_beat;
  logic [ADDR_WIDTH-1:0]          r_base;
  logic [SA_LENGTH*DATA_WIDTH-1:0] r_row;
  logic                           w_capture;
  logic                           w_beat_acc;
  logic                           w_last;
  logic [BW-1:0]                  w_slice;

  assign w_capture  = (r_state == S_IDLE) && in_valid;
  assign w_beat_acc = (r_state == S_SEND) && mem_ready;
  assign w_last     = (r_beat == CW'(BEATS - 1));
  assign w_slice    = r_row[int'(r_beat)*BW +: BW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)             w_next = S_SEND;
      S_SEND:  if (mem_ready && w_last)  w_next = S_DONE;
      S_DONE:                            w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_base <= '0;
    end else if (w_capture) begin
      r_beat <= '0;
      r_base <= base_addr;
    end else if (w_beat_acc && !w_last) begin
      r_beat <= r_beat + CW'(1);
    end
  end

  // Row storage carries no reset; its contents are only observed in S_SEND.
  always_ff @(posedge clk) begin
    if (w_capture) r_row <= in_data;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mem_valid = (r_state == S_SEND);
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = mem_valid ? (r_base + ADDR_WIDTH'(r_beat)) : '0;
  assign mem_wdata = mem_valid ? w_slice : '0;

`ifdef WB_ZERO_COUNT_EN
  localparam int ZW = $clog2(SA_LENGTH + 1);

  logic [ZW-1:0] r_zero_count;
  logic [ZW-1:0] w_lane_zeros;

  always_comb begin
    w_lane_zeros = '0;
    for (int j = 0; j < LANES; j++) begin
      if (w_slice[j*DATA_WIDTH +: DATA_WIDTH] == '0) w_lane_zeros = w_lane_zeros + ZW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_zero_count <= '0;
    else if (w_capture)  r_zero_count <= '0;
    else if (w_beat_acc) r_zero_count <= r_zero_count + w_lane_zeros;
  end

  assign zero_count = r_zero_count;
`endif

endmodule

// File: tb/tb_act_writeback.sv
// Self-checking bench for act_writeback: directed scenarios plus randomized rows with random backpressure.
module tb_act_writeback;
  localparam int DW    = 11;
  localparam int SL    = 8;
  localparam int LN    = 4;
  localparam int AW    = 4;
  localparam int BEATS = SL / LN;
  localparam int ZW    = $clog2(SL + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            mem_ready = 1'b0;
  logic [SL*DW-1:0] in_data = '0;
  logic [AW-1:0]   base_addr = '0;
  logic            in_ready, mem_valid, done, busy;
  logic [AW-1:0]   mem_addr;
  logic [LN*DW-1:0] mem_wdata;
`ifdef WB_ZERO_COUNT_EN
  logic [ZW-1:0]   zero_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  act_writeback #(.DATA_WIDTH(DW), .SA_LENGTH(SL), .LANES(LN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .base_addr(base_addr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .busy(busy)
`ifdef WB_ZERO_COUNT_EN
    , .zero_count(zero_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int r[SL], input int base);
    for (int k = 0; k < SL; k++) in_data[k*DW +: DW] = DW'(r[k]);
    base_addr = AW'(base);
    in_valid  = 1'b1;
  endtask

  task automatic scramble_inputs();
    for (int k = 0; k < SL; k++) in_data[k*DW +: DW] = DW'($urandom);
    base_addr = AW'($urandom);
  endtask

  // Reference model: beat k goes to (base+k) mod 2^AW, lane j carries element k*LN+j.
  function automatic logic [AW-1:0] exp_addr(input int base, input int k);
    return AW'((base + k) % (1 << AW));
  endfunction

  function automatic int lane(input logic [LN*DW-1:0] d, input int j);
    logic signed [DW-1:0] e;
    e = d[j*DW +: DW];
    return int'(e);
  endfunction

  function automatic int count_zeros(input int r[SL]);
    int n = 0;
    foreach (r[i]) if (r[i] == 0) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
    n_vec++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL reset_addr_data got %h/%h want 0/0", mem_addr, mem_wdata); end
`ifdef WB_ZERO_COUNT_EN
    n_vec++; if (zero_count !== '0) begin n_err++; $display("FAIL reset_zero_count got %0d want 0", zero_count); end
`endif
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_release got rdy=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_basic();
    int r[SL];
    r = '{1, -2, 3, -1024, 1023, 0, 5, -7};
    mem_ready = 1'b1;
    load_row(r, 3);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_ctl beat%0d got v=%b d=%b r=%b b=%b want 1 0 0 1", k, mem_valid, done, in_ready, busy); end
      n_vec++; if (mem_addr !== exp_addr(3, k)) begin n_err++; $display("FAIL basic_addr beat%0d got %0d want %0d", k, mem_addr, exp_addr(3, k)); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== r[k*LN+j]) begin n_err++; $display("FAIL basic_data beat%0d lane%0d got %0d want %0d", k, j, lane(mem_wdata, j), r[k*LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1 || mem_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_done got d=%b v=%b r=%b want 1 0 0", done, mem_valid, in_ready); end
    tick();
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got r=%b d=%b b=%b want 1 0 0", in_ready, done, busy); end
    tick();
  endtask

  task automatic test_backpressure();
    int r[SL];
    r = '{1, -2, 3, -1024, 1023, 0, 5, -7};
    mem_ready = 1'b1;
    load_row(r, 3);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b1 || mem_addr !== 4'd3) begin n_err++; $display("FAIL bp_beat0 got v=%b a=%0d want 1 3", mem_valid, mem_addr); end
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || done !== 1'b0 || mem_addr !== 4'd4) begin n_err++; $display("FAIL bp_hold c%0d got v=%b d=%b a=%0d want 1 0 4", c, mem_valid, done, mem_addr); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== r[LN+j]) begin n_err++; $display("FAIL bp_data c%0d lane%0d got %0d want %0d", c, j, lane(mem_wdata, j), r[LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1 || mem_valid !== 1'b0) begin n_err++; $display("FAIL bp_done got d=%b v=%b want 1 0", done, mem_valid); end
    tick();
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle got d=%b r=%b want 0 1", done, in_ready); end
    tick();
  endtask

  task automatic test_wrap();
    int r[SL];
    foreach (r[i]) r[i] = int'($urandom_range(0, 2047)) - 1024;
    mem_ready = 1'b1;
    load_row(r, 15);
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr(15, k)) begin n_err++; $display("FAIL wrap_addr beat%0d got v=%b a=%0d want 1 %0d", k, mem_valid, mem_addr, exp_addr(15, k)); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== r[k*LN+j]) begin n_err++; $display("FAIL wrap_data beat%0d lane%0d got %0d want %0d", k, j, lane(mem_wdata, j), r[k*LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ra[SL];
    int rb[SL];
    foreach (ra[i]) begin
      ra[i] = int'($urandom_range(0, 2047)) - 1024;
      rb[i] = int'($urandom_range(0, 2047)) - 1024;
    end
    mem_ready = 1'b1;
    load_row(ra, 2);
    tick();
    load_row(rb, 9);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || in_ready !== 1'b0 || mem_addr !== exp_addr(2, k)) begin n_err++; $display("FAIL b2b_a_beat%0d got v=%b r=%b a=%0d want 1 0 %0d", k, mem_valid, in_ready, mem_addr, exp_addr(2, k)); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== ra[k*LN+j]) begin n_err++; $display("FAIL b2b_a_data beat%0d lane%0d got %0d want %0d", k, j, lane(mem_wdata, j), ra[k*LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done got d=%b r=%b want 1 0", done, in_ready); end
    tick();
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || mem_valid !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept got r=%b v=%b want 1 0", in_ready, mem_valid); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr(9, k)) begin n_err++; $display("FAIL b2b_b_beat%0d got v=%b a=%0d want 1 %0d", k, mem_valid, mem_addr, exp_addr(9, k)); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== rb[k*LN+j]) begin n_err++; $display("FAIL b2b_b_data beat%0d lane%0d got %0d want %0d", k, j, lane(mem_wdata, j), rb[k*LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_b_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_midrow_reset();
    int ra[SL];
    int rc[SL];
    foreach (ra[i]) begin
      ra[i] = int'($urandom_range(0, 2047)) - 1024;
      rc[i] = int'($urandom_range(0, 2047)) - 1024;
    end
    mem_ready = 1'b1;
    load_row(ra, 6);
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (mem_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mrst_ctl got v=%b r=%b b=%b d=%b want 0 1 0 0", mem_valid, in_ready, busy, done); end
    n_vec++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL mrst_addr_data got %h/%h want 0/0", mem_addr, mem_wdata); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || in_ready !== 1'b1 || mem_valid !== 1'b0) begin n_err++; $display("FAIL mrst_after c%0d got d=%b r=%b v=%b want 0 1 0", c, done, in_ready, mem_valid); end
      tick();
    end
    load_row(rc, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      n_vec++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr(1, k)) begin n_err++; $display("FAIL mrst_new_beat%0d got v=%b a=%0d want 1 %0d", k, mem_valid, mem_addr, exp_addr(1, k)); end
      for (int j = 0; j < LN; j++) begin
        n_vec++; if (lane(mem_wdata, j) !== rc[k*LN+j]) begin n_err++; $display("FAIL mrst_new_data beat%0d lane%0d got %0d want %0d", k, j, lane(mem_wdata, j), rc[k*LN+j]); end
      end
      tick();
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL mrst_new_done got %b want 1", done); end
    tick();
  endtask

`ifdef WB_ZERO_COUNT_EN
  task automatic test_zero_count();
    int r[SL];
    int want;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) r = '{0, 0, 3, 0, 0, 0, -1, 0};
      else        r = '{0, 0, 0, 0, 0, 0, 0, 0};
      want = count_zeros(r);
      mem_ready = 1'b1;
      load_row(r, 0);
      tick();
      in_valid = 1'b0;
      repeat (BEATS) tick();
      @(negedge clk);
      n_vec++; if (done !== 1'b1 || zero_count !== ZW'(want)) begin n_err++; $display("FAIL zc_row%0d got d=%b zc=%0d want 1 %0d", t, done, zero_count, want); end
      tick();
      @(negedge clk);
      n_vec++; if (zero_count !== ZW'(want)) begin n_err++; $display("FAIL zc_hold%0d got %0d want %0d", t, zero_count, want); end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    int r[SL];
    int base;
    int beat;
    bit seen_done;
    for (int n = 0; n < 20; n++) begin
      foreach (r[i]) r[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2047)) - 1024;
      base = int'($urandom_range(0, (1 << AW) - 1));
      load_row(r, base);
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      in_valid = 1'b0;
      beat = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
        scramble_inputs();
        @(negedge clk);
        if (done === 1'b1) begin
          seen_done = 1'b1;
          n_vec++; if (beat !== BEATS || mem_valid !== 1'b0) begin n_err++; $display("FAIL rnd_done row%0d got beats=%0d v=%b want %0d 0", n, beat, mem_valid, BEATS); end
`ifdef WB_ZERO_COUNT_EN
          n_vec++; if (zero_count !== ZW'(count_zeros(r))) begin n_err++; $display("FAIL rnd_zc row%0d got %0d want %0d", n, zero_count, count_zeros(r)); end
`endif
        end else if (mem_valid === 1'b1 && beat < BEATS) begin
          n_vec++; if (mem_addr !== exp_addr(base, beat)) begin n_err++; $display("FAIL rnd_addr row%0d beat%0d got %0d want %0d", n, beat, mem_addr, exp_addr(base, beat)); end
          for (int j = 0; j < LN; j++) begin
            n_vec++; if (lane(mem_wdata, j) !== r[beat*LN+j]) begin n_err++; $display("FAIL rnd_data row%0d beat%0d lane%0d got %0d want %0d", n, beat, j, lane(mem_wdata, j), r[beat*LN+j]); end
          end
          if (mem_ready) beat++;
        end else begin
          n_vec++; n_err++;
          $display("FAIL rnd_ctl row%0d got v=%b d=%b beat=%0d want valid beat or done", n, mem_valid, done, beat);
          seen_done = 1'b1;
        end
        tick();
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (!seen_done) begin
        n_vec++; n_err++;
        $display("FAIL rnd_timeout row%0d got no done want done within 200 cycles", n);
      end
      mem_ready = 1'b1;
      repeat (3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_midrow_reset();
`ifdef WB_ZERO_COUNT_EN
    test_zero_count();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
